// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads big-endian words from the instruction ROM
// and hands them to decode through a one-entry valid/ready output register.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ROM_BYTES = 100,
  parameter logic [31:0] HALT_WORD = 32'hFC00_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic        rom_nrd,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted,
  output logic        fault,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {StRun, StHalt, StFault} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [15:0] fetch_count_q, fetch_count_d;

  logic [32:0] pc_end;
  logic        legal;
  logic        slot_free;
  logic        consume;
  logic        fetch;

  // 33-bit end address so a PC near 2^32 cannot wrap back into range
  assign pc_end    = {1'b0, pc_q} + 33'd4;
  assign legal     = (pc_q[1:0] == 2'b00) && (pc_end <= 33'(ROM_BYTES));
  assign slot_free = !out_valid_q || out_ready;
  assign consume   = out_valid_q && out_ready;
  assign fetch     = !Reset && (state_q == StRun) && slot_free && !redirect_valid && legal;

  assign rom_nrd     = !fetch;
  assign rom_addr    = pc_q;
  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_pc      = out_pc_q;
  assign halted      = (state_q == StHalt);
  assign fault       = (state_q == StFault);
  assign fetch_count = fetch_count_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    out_valid_d   = out_valid_q;
    out_instr_d   = out_instr_q;
    out_pc_d      = out_pc_q;
    fetch_count_d = fetch_count_q;

    if (consume && (fetch_count_q != 16'hFFFF)) begin
      fetch_count_d = fetch_count_q + 16'd1;
    end

    if (redirect_valid && (state_q != StFault)) begin
      out_valid_d = 1'b0;
      pc_d        = redirect_pc;
      state_d     = (redirect_pc[1:0] != 2'b00) ? StFault : StRun;
    end else if (fetch) begin
      out_valid_d = 1'b1;
      out_instr_d = rom_data;
      out_pc_d    = pc_q;
      pc_d        = pc_q + 32'd4;
      if (rom_data == HALT_WORD) begin
        state_d = StHalt;
      end
    end else begin
      if (consume) begin
        out_valid_d = 1'b0;
      end
      if ((state_q == StRun) && slot_free && !redirect_valid && !legal) begin
        state_d = StFault;
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q       <= StRun;
      pc_q          <= RESET_PC;
      out_valid_q   <= 1'b0;
      out_instr_q   <= 32'h0;
      out_pc_q      <= 32'h0;
      fetch_count_q <= 16'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_pc_q      <= out_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

endmodule
